// File: rtl/bit_serializer.sv
// Purpose: parallel-to-serial front end feeding a 1010 sequence detector's din.
// Latency: a word accepted from IDLE at edge k shows its first bit in cycle k+1 and its last bit in cycle k+WIDTH.
// Backpressure: s_ready = !pend_full; one word shifts while one more waits in the pending register.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  WIDTH-bit input word, valid/ready handshake
//   dout, dout_valid    serial bit (forced 0 when not valid) and its qualifier
//   word_done           one-cycle pulse alongside the last bit of each word
//   busy                shifting, in the inter-word gap, or holding a pending word
// Build option: define SER_LSB_FIRST_EN to shift LSB first (default MSB first).
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW      = $clog2(WIDTH);
    localparam int GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam bit NO_GAP  = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_full_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gcnt_q;
    logic             dout_q;
    logic             dout_valid_q;
    logic             word_done_q;
    logic             busy_q;

    logic             accept;
    logic             last_bit;
    logic             gap_end;
    logic             handoff;
    logic             load_pend;
    logic             load_byp;
    logic             pend_wr;
    logic             pend_full_d;
    logic             busy_d;
    logic [WIDTH-1:0] load_dat_d;

`ifdef SER_LSB_FIRST_EN
    function automatic logic head(input logic [WIDTH-1:0] w);
        return w[0];
    endfunction
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return w >> 1;
    endfunction
`else
    function automatic logic head(input logic [WIDTH-1:0] w);
        return w[WIDTH-1];
    endfunction
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return w << 1;
    endfunction
`endif

    assign s_ready    = !pend_full_q;
    assign accept     = s_valid && s_ready;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;

    always_comb begin
        last_bit    = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));
        gap_end     = (state_q == ST_GAP) && (gcnt_q == '0);
        // The slot of the current word ends either on its last bit (no gap)
        // or on the final gap cycle; that is when the next word may start.
        handoff     = (last_bit && NO_GAP) || gap_end;
        load_pend   = handoff && pend_full_q;
        // From IDLE, or at a handoff with nothing pending, the incoming word
        // goes straight into the shift register and never touches pend.
        load_byp    = accept && ((state_q == ST_IDLE) || (handoff && !pend_full_q));
        load_dat_d  = load_pend ? pend_q : s_data;
        pend_wr     = accept && !load_byp;
        pend_full_d = (pend_full_q && !load_pend) || pend_wr;
        busy_d      = load_pend || load_byp
                   || ((state_q == ST_SHIFT) && !(last_bit && NO_GAP))
                   || ((state_q == ST_GAP) && !gap_end)
                   || pend_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            cnt_q        <= '0;
            gcnt_q       <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
            busy_q      <= busy_d;
            word_done_q <= 1'b0;
            if (pend_wr) begin
                pend_q <= s_data;
            end
            if (load_pend || load_byp) begin
                // Present the first bit right away; sr keeps the remainder.
                state_q      <= ST_SHIFT;
                sr_q         <= adv(load_dat_d);
                cnt_q        <= '0;
                dout_q       <= head(load_dat_d);
                dout_valid_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (last_bit) begin
                            dout_q       <= 1'b0;
                            dout_valid_q <= 1'b0;
                            if (NO_GAP) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_GAP;
                                gcnt_q  <= GW'(NO_GAP ? 0 : GAP - 1);
                            end
                        end else begin
                            dout_q      <= head(sr_q);
                            sr_q        <= adv(sr_q);
                            cnt_q       <= cnt_q + CW'(1);
                            // cnt_q tracks the bit on dout now; flag the one coming next.
                            word_done_q <= (cnt_q == CW'(WIDTH - 2));
                        end
                    end
                    ST_GAP: begin
                        if (gap_end) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gcnt_q <= gcnt_q - GW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Purpose: randomized scoreboard bench for bit_serializer, one instance with GAP=0 and one with GAP=2.
// Latency: expected bit timeline derived from accept edges: start = max(accept edge, previous last bit + 1 + GAP).
// Backpressure: drivers hold s_valid until s_ready; the model predicts s_ready and busy per cycle.
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct {
        int c;
        bit b;
        bit last;
    } ebit_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        checks = 0;
        errors = 0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : lane
        localparam int G = 2 * gi;

        logic       rst_n = 1'b1;
        logic [W-1:0] s_data;
        logic       s_valid;
        logic       s_ready;
        logic       dout;
        logic       dout_valid;
        logic       word_done;
        logic       busy;
        bit         done;

        ebit_t q[$];
        int    last_end;
        int    busy_until;
        int    pend_e;
        int    pend_s;

        bit_serializer #(.WIDTH(W), .GAP(G)) dut (
            .clk        (clk),
            .rst        (rst_n),
            .s_data     (s_data),
            .s_valid    (s_valid),
            .s_ready    (s_ready),
            .dout       (dout),
            .dout_valid (dout_valid),
            .word_done  (word_done),
            .busy       (busy)
        );

        task automatic model_reset();
            q.delete();
            last_end   = -100;
            busy_until = -1;
            pend_e     = 0;
            pend_s     = 0;
        endtask

        // Word accepted at the coming edge e is shown from cycle start onward.
        task automatic push_word(input logic [W-1:0] w);
            int e;
            int st;
            logic [W-1:0] v;
            ebit_t x;
            v  = w;
            e  = cyc + 1;
            st = (e > last_end + 1 + G) ? e : last_end + 1 + G;
            for (int i = 0; i < W; i++) begin
                x.c = st + i;
`ifdef SER_LSB_FIRST_EN
                x.b = v[i];
`else
                x.b = v[W-1-i];
`endif
                x.last = (i == W - 1);
                q.push_back(x);
            end
            last_end   = st + W - 1;
            busy_until = last_end + G;
            pend_e     = e;
            pend_s     = st;
        endtask

        task automatic idle(input int n);
            repeat (n) begin
                @(negedge clk);
                #1;
            end
        endtask

        // Called at negedge+1; returns at negedge+1 of the cycle after the accept edge.
        task automatic send(input logic [W-1:0] w);
            int n;
            n       = 0;
            s_valid = 1'b1;
            s_data  = w;
            while (!s_ready && n < 200) begin
                idle(1);
                n++;
            end
            if (!s_ready) begin
                chk($sformatf("g%0d_send_timeout", G), int'(s_ready), 1);
            end else begin
                push_word(w);
                idle(1);
            end
            s_valid = 1'b0;
            s_data  = W'($urandom);
        endtask

        always @(negedge clk) begin
            int c;
            bit ev;
            bit eb;
            bit el;
            c  = cyc;
            ev = 1'b0;
            eb = 1'b0;
            el = 1'b0;
            if (q.size() > 0 && q[0].c == c) begin
                ev = 1'b1;
                eb = q[0].b;
                el = q[0].last;
                void'(q.pop_front());
            end
            chk($sformatf("g%0d_dout_valid", G), int'(dout_valid), int'(ev));
            chk($sformatf("g%0d_dout", G), int'(dout), int'(eb));
            chk($sformatf("g%0d_word_done", G), int'(word_done), int'(el));
            chk($sformatf("g%0d_busy", G), int'(busy), int'(c <= busy_until));
            chk($sformatf("g%0d_s_ready", G), int'(s_ready), int'(!(c >= pend_e && c < pend_s)));
        end

        initial begin
            done    = 1'b0;
            s_valid = 1'b0;
            s_data  = '0;
            model_reset();
            #1 rst_n = 1'b0;
            idle(3);
            rst_n = 1'b1;
            idle(1);

            send(8'hA5);
            idle(12);
            send(8'h0A);
            send(8'hAA);
            idle(14);
            send(8'h3C);
            send(8'hC3);
            send(8'h96);
            idle(30);

            for (int n = 0; n < 150; n++) begin
                send(W'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
            end
            idle(30);

            // Reset while bit 4 of a word is on dout and the next word waits in pend.
            send(8'hF8);
            send(8'h55);
            idle(3);
            rst_n = 1'b0;
            model_reset();
            #1;
            chk($sformatf("g%0d_arst_dout", G), int'(dout), 0);
            chk($sformatf("g%0d_arst_dout_valid", G), int'(dout_valid), 0);
            chk($sformatf("g%0d_arst_word_done", G), int'(word_done), 0);
            chk($sformatf("g%0d_arst_busy", G), int'(busy), 0);
            chk($sformatf("g%0d_arst_s_ready", G), int'(s_ready), 1);
            idle(2);
            rst_n = 1'b1;
            idle(1);
            send(8'h81);
            send(8'h7E);

            for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
            idle(4);
            chk($sformatf("g%0d_drain", G), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && !(lane[0].done && lane[1].done); i++) @(posedge clk);
        chk("finish", int'(lane[0].done && lane[1].done), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the non-overlapping 1010 sequence detector. Accepts WIDTH-bit words over a valid/ready handshake, buffers one pending word, and shifts them out one bit per clock on `dout`, which drives the detector's `din`. Supports gap-free back-to-back streaming and an optional idle gap between words.

## Interface

- `WIDTH`, 8: bits per word; legal range 2..32.
- `GAP`, 0: idle cycles inserted after each word; legal range 0..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronous to `clk`.
- `s_data`  in  WIDTH  parallel word to send.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial bit to the detector's `din`.
- `dout_valid`  out  1  `dout` carries a data bit this cycle.
- `word_done`  out  1  one-cycle pulse coincident with the last bit of a word.
- `busy`  out  1  high while shifting, in GAP, or while a pending word is held.

## Operation

- Storage:
  - shift register `sr[WIDTH-1:0]`
  - pending register `pend` with flag `pend_full`
  - bit counter `cnt` (0..WIDTH-1)
  - gap counter `gcnt`
- FSM states: IDLE, SHIFT, GAP. Reset state is IDLE.
- Handshake:
  - Accept when `s_valid && s_ready`.
  - `s_ready = !pend_full`, combinational from a register.
  - `s_data` is don't-care when `s_valid` is low.
- IDLE:
  - On accept, load `sr` directly, set `cnt=0`, go to SHIFT. `pend` is untouched.
- SHIFT:
  - Every cycle `dout` = current bit and `dout_valid=1`.
  - `sr` shifts by one and `cnt` increments.
  - An accept in this state writes `pend` and sets `pend_full`.
- Last bit (`cnt==WIDTH-1`):
  - `word_done=1`.
  - If GAP>0, go to GAP with `gcnt=GAP-1`.
  - Else if `pend_full`: load `sr` from `pend`, clear `pend_full`, stay in SHIFT.
  - Else if an accept occurs this cycle: bypass `s_data` straight into `sr` and stay in SHIFT.
  - Else go to IDLE.
- GAP:
  - `dout=0`, `dout_valid=0`.
  - When `gcnt` reaches 0:
    - If `pend_full`, load from `pend` and go to SHIFT.
    - Else if an accept occurs this cycle, bypass `s_data` into `sr` and go to SHIFT.
    - Else go to IDLE.
  - Accepts during GAP fill `pend` if it is empty.
- `dout` is forced to 0 whenever `dout_valid=0`, so the detector sees a defined 0 level between words.
- `busy = (state!=IDLE) || pend_full`.

## Timing

- Reset values: `dout=0`, `dout_valid=0`, `word_done=0`, `busy=0`, `s_ready=1`, `pend_full=0`, state IDLE.
- `dout`, `dout_valid`, `word_done` and `busy` are registered outputs.
- Latency: a word accepted at edge k from IDLE produces its first bit in cycle k+1 and its last bit in cycle k+WIDTH, with `word_done` high in cycle k+WIDTH.
- GAP=0 with a pending or bypassed word: the next word's first bit follows the previous last bit with no bubble.
- GAP=g: exactly g cycles with `dout_valid=0` separate consecutive words.
- Simultaneous accept and `pend` load on the last bit: `pend` empties while the new word fills `pend`. Net effect: `pend_full` stays 1 and `s_ready` stays 0 for that cycle's decision.
- Reset asserted mid-word:
  - The partial word and the pending word are discarded.
  - Outputs return to reset values asynchronously.
  - No `word_done` pulse is emitted for the partial word.

## Configuration

- `SER_LSB_FIRST_EN`:
  - Defined: bits shift out LSB first (`s_data[0]` first).
  - Undefined (default): bits shift out MSB first (`s_data[WIDTH-1]` first).
  - Handshake and timing are identical in both cases.

## Test plan

- Reset, then send 8'hA5 (MSB-first) -> `dout` = 1,0,1,0,0,1,0,1 over 8 consecutive cycles with `dout_valid=1`; `word_done` only on the 8th; then IDLE with `dout=0`.
- GAP=0, hold `s_valid` with 8'h0A then 8'hAA -> 16 contiguous valid bits 0000101010101010; `s_ready` drops after the 2nd accept and rises after `pend` loads.
- Present 3 words while the first is shifting -> the 3rd is held off (`s_ready=0`) until `pend` drains; no word lost or duplicated.
- GAP=2, two words back-to-back -> exactly 2 cycles of `dout_valid=0`, `dout=0` between them; `busy` stays 1 throughout.
- Assert `rst` low at bit 4 of a word with `pend` full -> all outputs at reset values immediately; after release `s_ready=1`, and the next word starts cleanly.
- With `SER_LSB_FIRST_EN`, send 8'hA5 -> `dout` = 1,0,1,0,0,1,0,1 (palindromic check); then send 8'h0A -> 0,1,0,1,0,0,0,0.
